// File: rtl/wave_gen_dds_pkg.sv
// Shared definitions for the DDS waveform generator: waveform select codes and
// default widths used by the top and its LUT RAM.
package wave_gen_dds_pkg;

   typedef enum logic [1:0] {
      WAVE_LUT = 2'd0,
      WAVE_SQR = 2'd1,
      WAVE_SAW = 2'd2,
      WAVE_TRI = 2'd3
   } wave_mode_e;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 9;
   localparam int DEF_ACC_W  = 32;

endpackage

// File: rtl/wave_lut_ram.sv
// Simple dual-port synchronous RAM holding the arbitrary waveform table.
// A read and a write to the same address in one cycle return the old data.
module wave_lut_ram
   import wave_gen_dds_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Both ports in one process so the read samples the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/wave_gen_dds.sv
// DDS waveform generator: phase accumulator plus a two-stage decode pipe that
// produces LUT, square, sawtooth or triangle samples for the DAC word path.
module wave_gen_dds
   import wave_gen_dds_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ACC_W-1:0]  freq_word,
   input  logic [ACC_W-1:0]  phase_off,
   input  logic              phase_rst,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] duty,
   input  logic              lut_we,
   input  logic [ADDR_W-1:0] lut_waddr,
   input  logic [DATA_W-1:0] lut_wdata,
   output logic [DATA_W-1:0] word_out,
   output logic              sample_valid,
   output logic              wrap
);

   // Handshake: sample_valid is a pure qualifier with no ready/backpressure;
   // word_out carries a new sample in every cycle sample_valid is high and
   // holds its previous value otherwise. wrap is only ever high with it.

   // Asynchronous assert, synchronous release of the internal reset.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync[1];

   // acc_wrap remembers that the current acc value was reached through a carry,
   // so the flag travels with the sample that is taken from that value.
   logic [ACC_W-1:0] acc;
   logic             acc_wrap;
   logic [ACC_W:0]   acc_sum;

   assign acc_sum = {1'b0, acc} + {1'b0, freq_word};

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         acc      <= '0;
         acc_wrap <= 1'b0;
      end else if (phase_rst) begin
         acc      <= '0;
         acc_wrap <= 1'b0;
      end else if (en) begin
         acc      <= acc_sum[ACC_W-1:0];
         acc_wrap <= acc_sum[ACC_W];
      end
   end

   logic [ACC_W-1:0]  p;
   logic              p_unused;
   logic [ADDR_W-1:0] lut_raddr;
   logic [DATA_W-1:0] tri_s;
   logic [DATA_W-1:0] tri_val;
   logic [DATA_W-1:0] lut_rdata;

   assign p         = acc + phase_off;
   assign p_unused  = ^p;
   assign lut_raddr = p[ACC_W-1 -: ADDR_W];
   assign tri_s     = p[ACC_W-2 -: DATA_W];
   assign tri_val   = p[ACC_W-1] ? ~tri_s : tri_s;

   wave_lut_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_lut (
      .clk     (clk),
      .wr_en   (lut_we),
      .wr_addr (lut_waddr),
      .wr_data (lut_wdata),
      .rd_en   (en),
      .rd_addr (lut_raddr),
      .rd_data (lut_rdata)
   );

   // Stage 1: capture decode inputs alongside the LUT read issued this cycle.
   logic              s1_valid;
   logic              s1_wrap;
   wave_mode_e        s1_mode;
   logic [DATA_W-1:0] s1_duty;
   logic [DATA_W-1:0] s1_pt;
   logic [DATA_W-1:0] s1_tri;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         s1_valid <= 1'b0;
         s1_wrap  <= 1'b0;
         s1_mode  <= WAVE_LUT;
         s1_duty  <= '0;
         s1_pt    <= '0;
         s1_tri   <= '0;
      end else begin
         s1_valid <= en;
         if (en) begin
            s1_wrap <= acc_wrap;
            s1_mode <= wave_mode_e'(mode);
            s1_duty <= duty;
            s1_pt   <= p[ACC_W-1 -: DATA_W];
            s1_tri  <= tri_val;
         end
      end
   end

   // Stage 2: waveform select into the output register.
   logic [DATA_W-1:0] next_word;

   always_comb begin
      next_word = s1_pt;
      case (s1_mode)
         WAVE_LUT: next_word = lut_rdata;
         WAVE_SQR: next_word = (s1_pt < s1_duty) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         WAVE_SAW: next_word = s1_pt;
         WAVE_TRI: next_word = s1_tri;
         default:  next_word = s1_pt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         word_out     <= '0;
         sample_valid <= 1'b0;
         wrap         <= 1'b0;
      end else begin
         sample_valid <= s1_valid;
         wrap         <= s1_valid & s1_wrap;
         if (s1_valid) begin
            word_out <= next_word;
         end
      end
   end

endmodule
